axi4_sram_slave: RTL and testbench

AXI4 responder (slave) backed by a word-addressed on-chip SRAM. It is the far end of the core's AXI4 master port and is used as a simulation and FPGA memory target. It handles one outstanding transaction at a time (read or write) with FIXED, INCR and WRAP bursts of 32-bit beats.

---
 rtl/axi4_sram_slave.sv | 189 ++++++++++++++++++
 tb/tb_axi4_sram_slave.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_sram_slave.sv
// AXI4 responder backed by a word-addressed SRAM.
// One outstanding transaction at a time; FIXED/INCR/WRAP bursts of 32-bit beats.
module axi4_sram_slave #(
  parameter int ID_WIDTH  = 4,
  parameter int MEM_WORDS = 4096
) (
  input  logic                clk,
  input  logic                a_rst_n,
  input  logic [ID_WIDTH-1:0] awid,
  input  logic [31:0]         awaddr,
  input  logic [7:0]          awlen,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [31:0]         wdata,
  input  logic [3:0]          wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_WIDTH-1:0] bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_WIDTH-1:0] arid,
  input  logic [31:0]         araddr,
  input  logic [7:0]          arlen,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_WIDTH-1:0] rid,
  output logic [31:0]         rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);
  localparam int IW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_e;
  typedef enum logic [1:0] {M_FIXED, M_INCR, M_WRAP} mode_e;

  logic [31:0] mem [MEM_WORDS];

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [31:0]           addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [31:0]           rdata_q, rdata_d;
  // Holds every ready low until the first clock after reset release.
  logic                  init_q;
  logic [31:0]           nxt;
  logic                  last_beat;
  logic                  mem_we;

  // Reserved burst codes and WRAP with an illegal length are flagged as errors.
  function automatic logic burst_bad(input logic [1:0] b, input logic [7:0] l);
    return (b == 2'b11) ||
           (b == 2'b10 && !(l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15));
  endfunction

  // Erroneous bursts fall back to INCR addressing.
  function automatic mode_e burst_mode(input logic [1:0] b, input logic [7:0] l);
    if (b == 2'b00) return M_FIXED;
    if (b == 2'b10 && !burst_bad(b, l)) return M_WRAP;
    return M_INCR;
  endfunction

  // WRAP container is (len+1)*4 bytes; the mask selects the in-container offset.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input mode_e m,
                                            input logic [7:0] l);
    logic [31:0] mask;
    mask = ({24'd0, l} << 2) | 32'h3;
    case (m)
      M_FIXED: return a;
      M_WRAP:  return (a & ~mask) | ((a + 32'd4) & mask);
      default: return a + 32'd4;
    endcase
  endfunction

  assign nxt       = next_addr(addr_q, mode_q, len_q);
  assign last_beat = (cnt_q == len_q);

  assign awready = init_q && (state_q == IDLE);
  assign arready = init_q && (state_q == IDLE) && !awvalid;
  assign wready  = (state_q == WDATA);
  assign bvalid  = (state_q == WRESP);
  assign bid     = (state_q == WRESP) ? id_q : '0;
  assign bresp   = (state_q == WRESP && err_q) ? 2'b10 : 2'b00;
  assign rvalid  = (state_q == RDATA);
  assign rid     = (state_q == RDATA) ? id_q : '0;
  assign rresp   = (state_q == RDATA && err_q) ? 2'b10 : 2'b00;
  assign rlast   = (state_q == RDATA) && last_beat;
  assign rdata   = rdata_q;
  assign mem_we  = (state_q == WDATA) && wvalid;

  // Next-state and datapath updates; reads prefetch the following word on each R handshake.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (awvalid && awready) begin
          id_d    = awid;
          addr_d  = awaddr;
          len_d   = awlen;
          mode_d  = burst_mode(awburst, awlen);
          err_d   = burst_bad(awburst, awlen);
          cnt_d   = '0;
          state_d = WDATA;
        end else if (arvalid && arready) begin
          id_d    = arid;
          addr_d  = araddr;
          len_d   = arlen;
          mode_d  = burst_mode(arburst, arlen);
          err_d   = burst_bad(arburst, arlen);
          cnt_d   = '0;
          rdata_d = mem[araddr[2 +: IW]];
          state_d = RDATA;
        end
      end
      WDATA: begin
        if (wvalid) begin
          addr_d = nxt;
          cnt_d  = cnt_q + 8'd1;
          if (wlast != last_beat) err_d = 1'b1;
          if (last_beat) state_d = WRESP;
        end
      end
      WRESP: begin
        if (bready) state_d = IDLE;
      end
      RDATA: begin
        if (rready) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            addr_d  = nxt;
            cnt_d   = cnt_q + 8'd1;
            rdata_d = mem[nxt[2 +: IW]];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and transaction registers.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q <= IDLE;
      mode_q  <= M_INCR;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      init_q  <= 1'b1;
    end
  end

  // SRAM byte-lane writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[addr_q[2 +: IW]][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave.
module tb_axi4_sram_slave;
  logic        clk = 1'b0;
  logic        a_rst_n;
  logic [3:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [7:0]  awlen, arlen;
  logic [1:0]  awburst, bresp, arburst, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [3:0]  wstrb;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi4_sram_slave #(.ID_WIDTH(4), .MEM_WORDS(4096)) dut (
    .clk(clk), .a_rst_n(a_rst_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tmo(input string tag);
    n_chk++;
    n_fail++;
    $error("FAIL %s: timeout waiting for handshake", tag);
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l,
                         input logic [1:0] b);
    int n;
    awid = id; awaddr = a; awlen = l; awburst = b; awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 100) begin n++; @(negedge clk); end
    if (!awready) tmo("aw");
    @(posedge clk); #1 awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic l);
    int n;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!wready && n < 100) begin n++; @(negedge clk); end
    if (!wready) tmo("w");
    @(posedge clk); #1 wvalid = 1'b0;
  endtask

  task automatic b_get(input string tag, input logic [3:0] id, input logic [1:0] resp);
    int n;
    bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bvalid && n < 100) begin n++; @(negedge clk); end
    if (!bvalid) tmo({tag, "_b"});
    else begin
      chk({tag, "_bid"}, 32'(bid), 32'(id));
      chk({tag, "_bresp"}, 32'(bresp), 32'(resp));
    end
    @(posedge clk); #1 bready = 1'b0;
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l,
                         input logic [1:0] b);
    int n;
    arid = id; araddr = a; arlen = l; arburst = b; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 100) begin n++; @(negedge clk); end
    if (!arready) tmo("ar");
    @(posedge clk); #1 arvalid = 1'b0;
  endtask

  // Leaves rready high so consecutive calls take beats back to back.
  task automatic r_get(input string tag, input logic [31:0] d, input logic [1:0] resp,
                       input logic last, input logic [3:0] id, output int waits);
    int n;
    rready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rvalid && n < 100) begin n++; @(negedge clk); end
    waits = n;
    if (!rvalid) tmo({tag, "_r"});
    else begin
      chk({tag, "_rdata"}, rdata, d);
      chk({tag, "_rresp"}, 32'(rresp), 32'(resp));
      chk({tag, "_rlast"}, 32'(rlast), 32'(last));
      chk({tag, "_rid"}, 32'(rid), 32'(id));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int w;
    int beats;
    logic [5:0] rr_seq;
    a_rst_n = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;

    // Reset state
    #3;
    chk("rst_awready", 32'(awready), 0);
    chk("rst_arready", 32'(arready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rlast", 32'(rlast), 0);
    #9 a_rst_n = 1'b1;
    #1 chk("post_rst_awready", 32'(awready), 0);
    @(negedge clk);
    chk("idle_awready", 32'(awready), 1);
    chk("idle_arready", 32'(arready), 1);
    @(posedge clk); #1;

    // Single write then read back
    aw_send(4'd3, 32'h100, 8'd0, 2'b01);
    w_send(32'hDEADBEEF, 4'hF, 1'b1);
    b_get("single", 4'd3, 2'b00);
    ar_send(4'd5, 32'h100, 8'd0, 2'b01);
    r_get("single", 32'hDEADBEEF, 2'b00, 1'b1, 4'd5, w);
    chk("single_rlat", 32'(w), 0);
    rready = 1'b0;
    @(negedge clk);
    chk("single_rvalid_drop", 32'(rvalid), 0);
    @(posedge clk); #1;

    // INCR write with a partial strobe over a preloaded region
    aw_send(4'd1, 32'h200, 8'd3, 2'b01);
    for (int i = 0; i < 4; i++) w_send(32'hFFFFFFFF, 4'hF, i == 3);
    b_get("preload", 4'd1, 2'b00);
    aw_send(4'd2, 32'h200, 8'd3, 2'b01);
    w_send(32'h11111111, 4'hF, 1'b0);
    w_send(32'h22222222, 4'h3, 1'b0);
    w_send(32'h33333333, 4'hF, 1'b0);
    w_send(32'h44444444, 4'hF, 1'b1);
    b_get("incr", 4'd2, 2'b00);
    ar_send(4'd4, 32'h200, 8'd3, 2'b01);
    r_get("incr0", 32'h11111111, 2'b00, 1'b0, 4'd4, w);
    r_get("incr1", 32'hFFFF2222, 2'b00, 1'b0, 4'd4, w);
    chk("incr1_nobubble", 32'(w), 0);
    r_get("incr2", 32'h33333333, 2'b00, 1'b0, 4'd4, w);
    r_get("incr3", 32'h44444444, 2'b00, 1'b1, 4'd4, w);
    rready = 1'b0;

    // WRAP reads
    aw_send(4'd1, 32'h30, 8'd3, 2'b01);
    w_send(32'hA0A0A0A0, 4'hF, 1'b0);
    w_send(32'hA1A1A1A1, 4'hF, 1'b0);
    w_send(32'hA2A2A2A2, 4'hF, 1'b0);
    w_send(32'hA3A3A3A3, 4'hF, 1'b1);
    b_get("wpre", 4'd1, 2'b00);
    ar_send(4'd6, 32'h38, 8'd3, 2'b10);
    r_get("wrap0", 32'hA2A2A2A2, 2'b00, 1'b0, 4'd6, w);
    r_get("wrap1", 32'hA3A3A3A3, 2'b00, 1'b0, 4'd6, w);
    r_get("wrap2", 32'hA0A0A0A0, 2'b00, 1'b0, 4'd6, w);
    r_get("wrap3", 32'hA1A1A1A1, 2'b00, 1'b1, 4'd6, w);
    rready = 1'b0;
    ar_send(4'd7, 32'h30, 8'd2, 2'b10);
    r_get("bwrap0", 32'hA0A0A0A0, 2'b10, 1'b0, 4'd7, w);
    r_get("bwrap1", 32'hA1A1A1A1, 2'b10, 1'b0, 4'd7, w);
    r_get("bwrap2", 32'hA2A2A2A2, 2'b10, 1'b1, 4'd7, w);
    rready = 1'b0;

    // AW and AR valid together: write wins, read waits for the B handshake
    awid = 4'd6; awaddr = 32'h300; awlen = 8'd0; awburst = 2'b01; awvalid = 1'b1;
    arid = 4'd7; araddr = 32'h100; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1;
    @(negedge clk);
    chk("both_awready", 32'(awready), 1);
    chk("both_arready", 32'(arready), 0);
    @(posedge clk); #1 awvalid = 1'b0;
    @(negedge clk);
    chk("both_arready_wdata", 32'(arready), 0);
    @(posedge clk); #1;
    w_send(32'h12345678, 4'hF, 1'b1);
    @(negedge clk);
    chk("both_arready_wresp", 32'(arready), 0);
    @(posedge clk); #1;
    b_get("both", 4'd6, 2'b00);
    #4;
    chk("both_arready_after_b", 32'(arready), 1);
    @(posedge clk); #1 arvalid = 1'b0;
    r_get("both", 32'hDEADBEEF, 2'b00, 1'b1, 4'd7, w);
    rready = 1'b0;

    // FIXED read with rready backpressure
    ar_send(4'd2, 32'h300, 8'd2, 2'b00);
    rr_seq = 6'b101001;
    beats = 0;
    for (int k = 0; k < 6; k++) begin
      rready = rr_seq[k];
      @(negedge clk);
      chk($sformatf("fix%0d_rvalid", k), 32'(rvalid), 1);
      chk($sformatf("fix%0d_rdata", k), rdata, 32'h12345678);
      chk($sformatf("fix%0d_rlast", k), 32'(rlast), 32'(beats == 2));
      if (rvalid && rready) beats++;
      @(posedge clk); #1;
    end
    rready = 1'b0;
    chk("fix_beats", 32'(beats), 3);
    @(negedge clk);
    chk("fix_rvalid_drop", 32'(rvalid), 0);
    @(posedge clk); #1;

    // Early wlast yields SLVERR
    aw_send(4'd8, 32'h400, 8'd1, 2'b01);
    w_send(32'h55, 4'hF, 1'b1);
    w_send(32'h66, 4'hF, 1'b1);
    b_get("wlast_err", 4'd8, 2'b10);

    // Reset in the middle of a long write
    aw_send(4'd9, 32'h500, 8'd7, 2'b01);
    w_send(32'hB0B0B0B0, 4'hF, 1'b0);
    w_send(32'hB1B1B1B1, 4'hF, 1'b0);
    wdata = 32'hB2B2B2B2; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    #2 a_rst_n = 1'b0;
    #1;
    chk("mrst_wready", 32'(wready), 0);
    chk("mrst_awready", 32'(awready), 0);
    chk("mrst_arready", 32'(arready), 0);
    chk("mrst_bvalid", 32'(bvalid), 0);
    chk("mrst_rvalid", 32'(rvalid), 0);
    chk("mrst_rdata", rdata, 0);
    chk("mrst_bid", 32'(bid), 0);
    wvalid = 1'b0;
    @(posedge clk); #3 a_rst_n = 1'b1;
    @(posedge clk); #1;
    ar_send(4'd10, 32'h500, 8'd1, 2'b01);
    r_get("mrst0", 32'hB0B0B0B0, 2'b00, 1'b0, 4'd10, w);
    r_get("mrst1", 32'hB1B1B1B1, 2'b00, 1'b1, 4'd10, w);
    rready = 1'b0;
    aw_send(4'd11, 32'h600, 8'd0, 2'b01);
    w_send(32'hCAFEF00D, 4'hF, 1'b1);
    b_get("mrst_w", 4'd11, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
